uart_ram_loader: RTL and testbench

- Receives a program image over a serial UART line (8N1) and writes it byte-by-byte into the CPU's 16x8 RAM through a dedicated write port.
- This is the input side of the board interface. The board already drives CPU state out to LEDs; this block feeds external data into the CPU.
- While loading, it holds the CPU in reset. It also reports completion and error status for the board LEDs.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/uart_ram_loader_uart_rx.sv | 85 ++++++++
 rtl/uart_ram_loader.sv | 115 +++++++++++
 tb/tb_uart_ram_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU board: loader FSM states and RAM geometry.
package cpu_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} loader_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'h55;
    localparam int         RAM_DEPTH        = 16;
    localparam int         RAM_ADDR_WIDTH   = 4;

endpackage

// File: rtl/uart_ram_loader_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with start-glitch rejection, one-cycle result pulses.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          rx_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            rx_prev_reg <= 1'b1;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            frame_err   <= 1'b0;
        end else begin
            rx_prev_reg <= rx_sync;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync) begin
                        state_reg <= RX_START;
                        cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        // Line back high at mid start bit means it was only a glitch
                        state_reg   <= rx_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) state_reg <= RX_STOP;
                        else bit_idx_reg <= bit_idx_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == FULL_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Loads a sync-framed, checksummed program image from UART into the CPU RAM write port,
// holding the CPU in reset while a frame is in flight.
module uart_ram_loader
    import cpu_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 234,
    parameter int          DEPTH          = RAM_DEPTH,
    parameter int          ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 2_700_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] LAST_COUNT   = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [TW-1:0]       TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          rx_meta_reg, rx_sync_reg;
    logic          byte_valid, frame_err;
    logic [7:0]    byte_data;
    loader_state_t state_reg;
    logic [7:0]    checksum_reg;
    logic [TW-1:0] idle_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_sync    (rx_sync_reg),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            byte_count   <= '0;
            checksum_reg <= '0;
            idle_cnt_reg <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    idle_cnt_reg <= '0;
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        state_reg    <= DATA;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        byte_count   <= '0;
                        checksum_reg <= '0;
                        wr_addr      <= '0;
                    end
                end
                DATA, CHECK: begin
                    if (frame_err) begin
                        err       <= 1'b1;
                        cpu_hold  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (byte_valid) begin
                        idle_cnt_reg <= '0;
                        if (state_reg == DATA) begin
                            wr_en        <= 1'b1;
                            wr_data      <= byte_data;
                            wr_addr      <= byte_count[ADDR_WIDTH-1:0];
                            byte_count   <= byte_count + 1'b1;
                            checksum_reg <= checksum_reg + byte_data;
                            if (byte_count == LAST_COUNT) state_reg <= CHECK;
                        end else begin
                            // Trailing byte is the mod-256 sum of the image
                            if (byte_data == checksum_reg) done <= 1'b1;
                            else err <= 1'b1;
                            cpu_hold  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (idle_cnt_reg == TIMEOUT_LAST) begin
                        err       <= 1'b1;
                        cpu_hold  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: serial stimulus, write scoreboard and per-scenario status checks.
module tb_uart_ram_loader;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold, done, err;
    logic [4:0] byte_count;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    logic [7:0] frame_data [16];

    always #5 clk = ~clk;

    uart_ram_loader #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    // Every RAM write must match the next expected (addr, data) in order
    always @(negedge clk) begin
        if (wr_en) begin
            n_writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr=%0d data=%h ok", wr_addr, wr_data);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        $display("tx byte=%h stop=%b", b, stop_bit);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(4);
    endtask

    task automatic send_data(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = i[3:0];
            e.data = frame_data[i];
            exp_q.push_back(e);
            send_byte(frame_data[i], 1'b1);
        end
    endtask

    function automatic logic [7:0] image_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + frame_data[i];
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        n_checks++;
        if ({wr_en, wr_addr, wr_data, cpu_hold, done, err, byte_count} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got en=%b addr=%0d data=%h hold=%b done=%b err=%b cnt=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, cpu_hold, done, err, byte_count);
        end
    endtask

    task automatic run_frame(input logic [7:0] csum, input logic expect_good, input string tag);
        n_writes = 0;
        send_byte(8'h55, 1'b1);
        wait_clks(2);
        n_checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: got hold=%b done=%b err=%b, expected 1 0 0", tag, cpu_hold, done, err);
        end
        send_data(16);
        n_checks++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_hold_before_csum: got %b, expected 1", tag, cpu_hold);
        end
        send_byte(csum, 1'b1);
        wait_clks(4);
        n_checks++;
        if (done !== expect_good || err !== !expect_good || cpu_hold !== 1'b0 ||
            byte_count !== 5'd16 || n_writes != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_end: got done=%b err=%b hold=%b cnt=%0d writes=%0d, expected done=%b err=%b hold=0 cnt=16 writes=16",
                     tag, done, err, cpu_hold, byte_count, n_writes, expect_good, !expect_good);
        end
    endtask

    task automatic test_good_frame();
        run_frame(image_sum(), 1'b1, "good_frame");
    endtask

    task automatic test_bad_checksum();
        run_frame(image_sum() + 8'h01, 1'b0, "bad_checksum");
    endtask

    task automatic test_framing_error();
        n_writes = 0;
        send_byte(8'h55, 1'b1);
        send_data(3);
        send_byte(8'h42, 1'b0);
        wait_clks(4);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || byte_count !== 5'd3 || n_writes != 3) begin
            n_fail++;
            $display("FAIL framing_error: got err=%b done=%b hold=%b cnt=%0d writes=%0d, expected 1 0 0 3 3",
                     err, done, cpu_hold, byte_count, n_writes);
        end
        test_good_frame();
    endtask

    task automatic test_idle_noise();
        n_writes = 0;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h00, 1'b1);
        n_checks++;
        if (n_writes != 0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_noise: got writes=%0d hold=%b, expected 0 0", n_writes, cpu_hold);
        end
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(30);
        n_checks++;
        if (cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_hold: got %b, expected 0", cpu_hold);
        end
        send_byte(8'h55, 1'b1);
        wait_clks(2);
        n_checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_after_glitch: got hold=%b done=%b, expected 1 0", cpu_hold, done);
        end
        wait_clks(600);
        n_checks++;
        if (err !== 1'b1 || cpu_hold !== 1'b0 || n_writes != 0) begin
            n_fail++;
            $display("FAIL empty_frame_timeout: got err=%b hold=%b writes=%0d, expected 1 0 0", err, cpu_hold, n_writes);
        end
    endtask

    task automatic test_timeout();
        n_writes = 0;
        send_byte(8'h55, 1'b1);
        send_data(5);
        wait_clks(600);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || byte_count !== 5'd5 || n_writes != 5) begin
            n_fail++;
            $display("FAIL timeout: got err=%b done=%b hold=%b cnt=%0d writes=%0d, expected 1 0 0 5 5",
                     err, done, cpu_hold, byte_count, n_writes);
        end
    endtask

    task automatic test_reset_mid_frame();
        n_writes = 0;
        send_byte(8'h55, 1'b1);
        send_data(8);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        n_checks++;
        if ({wr_en, wr_addr, wr_data, cpu_hold, done, err, byte_count} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got en=%b addr=%0d data=%h hold=%b done=%b err=%b cnt=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, cpu_hold, done, err, byte_count);
        end
        for (int i = 8; i < 16; i++) send_byte(frame_data[i], 1'b1);
        send_byte(image_sum(), 1'b1);
        wait_clks(4);
        n_checks++;
        if (n_writes != 8 || cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_count !== 5'd0) begin
            n_fail++;
            $display("FAIL after_reset_ignored: got writes=%0d hold=%b done=%b err=%b cnt=%0d, expected 8 0 0 0 0",
                     n_writes, cpu_hold, done, err, byte_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) frame_data[i] = 8'h00;
        frame_data[0] = 8'h1E;
        frame_data[1] = 8'h2F;
        frame_data[2] = 8'hE0;
        frame_data[3] = 8'hF0;
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_framing_error();
        test_idle_noise();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
